// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle of the nibble-serial adder: operands and start in,
// busy/done/result out.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract sequenced through one external 4-bit CLA, one nibble per
// cycle, LSB nibble first, with the carry chained through a register.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus,
    output logic [3:0]           nib_a_o,
    output logic [3:0]           nib_b_o,
    output logic                 nib_cin_o,
    input  logic [3:0]           nib_s_i,
    input  logic                 nib_cout_i
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        nib_a_o   = 4'h0;
        nib_b_o   = 4'h0;
        nib_cin_o = 1'b0;

        // Subtract is folded into the operand load as a + ~b + 1.
        if (state_q != RUN && bus.start) begin
            state_d = RUN;
            a_d     = bus.a;
            b_d     = bus.sub ? ~bus.b : bus.b;
            carry_d = bus.sub ? 1'b1 : bus.cin;
            idx_d   = '0;
            sum_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    nib_a_o   = a_q[{idx_q, 2'b00} +: 4];
                    nib_b_o   = b_q[{idx_q, 2'b00} +: 4];
                    nib_cin_o = carry_q;
                    sum_d[{idx_q, 2'b00} +: 4] = nib_s_i;
                    carry_d   = nib_cout_i;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == IDXW'(NIB - 1)) begin
                        state_d = DONE;
                        cout_d  = nib_cout_i;
                        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (nib_s_i[3] != a_q[WIDTH-1]);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: behavioural CLA on the nibble port, directed
// scenarios plus randomized operations checked against a wide-arithmetic model.
module tb_nibble_serial_adder;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] nib_a, nib_b, nib_s;
    logic       nib_cin, nib_cout;
    int         n_cmp = 0;
    int         n_err = 0;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .nib_a_o    (nib_a),
        .nib_b_o    (nib_b),
        .nib_cin_o  (nib_cin),
        .nib_s_i    (nib_s),
        .nib_cout_i (nib_cout)
    );

    // External 4-bit CLA, purely combinational.
    assign {nib_cout, nib_s} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, nib_cin};

    always #5 clk = ~clk;

    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub,
                                   output logic [W-1:0] s, output logic co,
                                   output logic ov);
        longint ua, ub, r, sa, sb, sv;
        ua = longint'(a);
        ub = sub ? (longint'(65535) - longint'(b)) : longint'(b);
        r  = ua + ub + (sub ? 64'sd1 : longint'(cin));
        s  = r[W-1:0];
        co = r[W];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sv = sub ? (sa - sb) : (sa + sb + longint'(cin));
        ov = (sv > 32767) || (sv < -32768);
    endfunction

    // Launches one operation from a negedge and returns at the negedge where done
    // is seen (or after a 20-cycle bound). Optionally pokes start mid-RUN.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input bit poke,
                          output logic [W-1:0] s, output logic co, output logic ov,
                          output int lat, output int busyn,
                          output logic [3:0] cin_trace, output bit both);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
        @(negedge clk);
        lat = 0; busyn = 0; both = 0; cin_trace = 4'h0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) begin
                busyn++;
                if (lat < 4) cin_trace[lat[1:0]] = nib_cin;
            end
            bus.start = poke && (lat == 1);
            bus.a = W'($urandom); bus.b = W'($urandom);
            bus.cin = 1'($urandom); bus.sub = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        if (bus.busy && bus.done) both = 1;
        s = bus.sum; co = bus.cout; ov = bus.overflow;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 0; bus.sub = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.overflow);
        end
        n_cmp++;
        if ({nib_a, nib_b, nib_cin} !== 9'h0) begin
            n_err++;
            $display("FAIL reset_nibble got %h/%h/%b want 0", nib_a, nib_b, nib_cin);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_basic();
        logic [W-1:0] s; logic co, ov; int lat, bn; logic [3:0] tr; bit both;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, s, co, ov, lat, bn, tr, both);
        n_cmp++;
        if ({s, co, ov} !== {16'h5555, 1'b0, 1'b0} || lat != 4) begin
            n_err++;
            $display("FAIL add_basic got sum=%h cout=%b ovf=%b lat=%0d want 5555 0 0 lat=4",
                     s, co, ov, lat);
        end
        n_cmp++;
        if (bn != 4 || both) begin
            n_err++;
            $display("FAIL add_basic_busy got busy_cycles=%0d overlap=%0d want 4 0", bn, both);
        end
        // done is a single-cycle pulse and the result holds afterwards
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== 16'h5555) begin
            n_err++;
            $display("FAIL done_pulse got done=%b busy=%b sum=%h want 0 0 5555",
                     bus.done, bus.busy, bus.sum);
        end
        n_cmp++;
        if ({nib_a, nib_b, nib_cin} !== 9'h0) begin
            n_err++;
            $display("FAIL idle_nibble got %h/%h/%b want 0", nib_a, nib_b, nib_cin);
        end
    endtask

    task automatic test_ripple();
        logic [W-1:0] s; logic co, ov; int lat, bn; logic [3:0] tr; bit both;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, s, co, ov, lat, bn, tr, both);
        n_cmp++;
        if ({s, co} !== {16'h0000, 1'b1} || lat != 4) begin
            n_err++;
            $display("FAIL ripple got sum=%h cout=%b lat=%0d want 0000 1 lat=4", s, co, lat);
        end
        n_cmp++;
        if (tr !== 4'b1110) begin
            n_err++;
            $display("FAIL ripple_carry got nib_cin trace=%b want 1110", tr);
        end
        @(negedge clk);
    endtask

    task automatic test_subtract();
        logic [W-1:0] s; logic co, ov; int lat, bn; logic [3:0] tr; bit both;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, s, co, ov, lat, bn, tr, both);
        n_cmp++;
        if ({s, co, ov} !== {16'hFFFE, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL sub_neg got sum=%h cout=%b ovf=%b want fffe 0 0", s, co, ov);
        end
        @(negedge clk);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, s, co, ov, lat, bn, tr, both);
        n_cmp++;
        if ({s, co, ov} !== {16'h7FFF, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL sub_ovf got sum=%h cout=%b ovf=%b want 7fff 1 1", s, co, ov);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] s; logic co, ov; int lat, bn; logic [3:0] tr; bit both;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, s, co, ov, lat, bn, tr, both);
        n_cmp++;
        if ({s, co, ov} !== {16'h8000, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL add_ovf got sum=%h cout=%b ovf=%b want 8000 0 1", s, co, ov);
        end
        // issued in the done cycle
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, s, co, ov, lat, bn, tr, both);
        n_cmp++;
        if ({s, co, ov} !== {16'h0002, 1'b0, 1'b0} || lat != 4) begin
            n_err++;
            $display("FAIL back_to_back got sum=%h cout=%b ovf=%b lat=%0d want 0002 0 0 lat=4",
                     s, co, ov, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_start_in_run();
        logic [W-1:0] s; logic co, ov; int lat, bn; logic [3:0] tr; bit both;
        run_op(16'h0F0F, 16'h1111, 1'b1, 1'b0, 1, s, co, ov, lat, bn, tr, both);
        n_cmp++;
        if ({s, co, ov} !== {16'h2021, 1'b0, 1'b0} || bn != 4 || lat != 4) begin
            n_err++;
            $display("FAIL start_in_run got sum=%h cout=%b ovf=%b busy=%0d lat=%0d want 2021 0 0 4 4",
                     s, co, ov, bn, lat);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_run_idle got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s; logic co, ov; int lat, bn, dn; logic [3:0] tr; bit both;
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, s, co, ov, lat, bn, tr, both);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h2345; bus.cin = 0; bus.sub = 0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_run got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        n_cmp++;
        if (dn != 0) begin
            n_err++;
            $display("FAIL reset_no_done got active_cycles=%0d want 0", dn);
        end
        run_op(16'h1234, 16'h2345, 1'b0, 1'b0, 0, s, co, ov, lat, bn, tr, both);
        n_cmp++;
        if ({s, co, ov} !== {16'h3579, 1'b0, 1'b0} || lat != 4) begin
            n_err++;
            $display("FAIL after_reset got sum=%h cout=%b ovf=%b lat=%0d want 3579 0 0 lat=4",
                     s, co, ov, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] s, es, a, b; logic co, ov, eco, eov, cin, sub;
        int lat, bn; logic [3:0] tr; bit both;
        logic [W-1:0] corner [4];
        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            ref_op(a, b, cin, sub, es, eco, eov);
            run_op(a, b, cin, sub, ($urandom_range(0, 3) == 0), s, co, ov, lat, bn, tr, both);
            n_cmp++;
            if ({s, co, ov} !== {es, eco, eov} || lat != 4 || bn != 4 || both) begin
                n_err++;
                $display("FAIL random[%0d] a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b lat=%0d busy=%0d want %h %b %b lat=4 busy=4",
                         i, a, b, cin, sub, s, co, ov, lat, bn, es, eco, eov);
            end
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_ripple();
        test_subtract();
        test_back_to_back();
        test_start_in_run();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
